sevenseg_scan_ctrl: RTL and testbench
=====================================

// Module: sevenseg_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for an N-digit common-anode 7-seg display.
//   Shares one external combinational BCD->7-seg decoder across all digits.
//   Each digit slot presents that digit's BCD code and drives its anode.
//   Double-buffers the displayed value via a load/ack handshake; updates land on frame boundaries.
// PARAMETERS
//   N_DIGITS     8       number of digits scanned (2..8)
//   REFRESH_DIV  100000  clk cycles per digit slot (>= GUARD+2)
//   GUARD        4       cycles at start of each slot with all anodes off (anti-ghosting)
//   BLANK_LZ     1       1 = blank leading zeros, 0 = show all digits
// PORTS
//   clk           in   1           system clock, all state on rising edge
//   reset         in   1           synchronous, active-low reset
//   bcd_in        in   4*N_DIGITS  new value; digit i = bcd_in[4i+3:4i], digit 0 = LSD
//   dp_in         in   N_DIGITS    new decimal points, 1 = lit
//   load          in   1           level request to capture bcd_in/dp_in
//   load_ack      out  1           1-cycle pulse: capture done this cycle
//   bcd_sel       out  4           BCD code of current digit, to shared decoder
//   seg_from_dec  in   7           decoder result {a,b,c,d,e,f,g}, active-high
//   segments_n    out  7           cathodes {a..g}, active-low
//   dp_n          out  1           decimal point cathode, active-low
//   anodes_n      out  N_DIGITS    digit enables, active-low, one-hot-low in DRIVE
//   frame_done    out  1           1-cycle pulse when digit N_DIGITS-1 slot ends
// BEHAVIOUR
//   Reset (reset==0 at clk edge): prescaler=0, idx=0, state=GUARD, shadow bcd/dp=0,
//     anodes_n=all 1, bcd_sel=0, dp_n=1, load_ack=0, frame_done=0. Applies mid-frame;
//     pending load is not acked; load still high after reset is taken at first boundary.
//   Prescaler counts 0..REFRESH_DIV-1 per slot; terminal count -> prescaler=0,
//     idx=idx+1, wrapping N_DIGITS-1 -> 0.
//   FSM per slot: GUARD (prescaler < GUARD) -> DRIVE (prescaler >= GUARD) -> GUARD on terminal.
//     GUARD: anodes_n=all 1, segments_n=7'h7F, dp_n=1.
//     DRIVE: anodes_n[idx]=0 and all others 1.
//   bcd_sel = shadow digit idx, registered; changes in the same cycle idx changes.
//   segments_n is combinational from seg_from_dec and registered flags: ~seg_from_dec normally.
//   Invalid code (shadow digit > 9): segments_n=7'b1111110 (dash, g only), seg_from_dec ignored.
//   Leading-zero blank (BLANK_LZ=1): digit i blanked when digits N_DIGITS-1..i are all 0
//     and i != 0. Blanked: segments_n=7'h7F, anode still driven; dp follows dp shadow.
//     Digit 0 is never blanked, so 0 displays as a single "0".
//   dp_n = ~dp_shadow[idx] in DRIVE.
//   frame_done: asserted the cycle after the terminal count of slot N_DIGITS-1 (idx now 0).
//   Load handshake: if load==1 on the cycle of the terminal count of slot N_DIGITS-1,
//     shadow <= {bcd_in, dp_in} and load_ack=1 in the following cycle (aligned with frame_done).
//     The new value first shows in slot 0 of the new frame; no mid-frame tearing.
//     load is sampled only at that boundary; load held across boundaries -> one ack per frame.
//     Requester must deassert load after ack; bcd_in must be stable while load=1.
//   Outputs other than segments_n are registered; no combinational path from load to load_ack.
// TESTING  (N_DIGITS=4, REFRESH_DIV=8, GUARD=2, BLANK_LZ=1, model decoder on seg_from_dec)
//   1 reset=0 for 2 cycles -> anodes_n=4'b1111, segments_n=7'h7F, dp_n=1, load_ack=0, bcd_sel=0.
//   2 load 0x1234 then release; scan -> per 8-cycle slot 2 cycles of anodes_n=1111, then
//     6 cycles of anodes_n=1110 with bcd_sel=4, then 1101/3, 1011/2, 0111/1;
//     frame_done every 32 cycles.
//   3 hold load=1 with 0x5678 mid-frame -> no change until boundary; single load_ack coincident
//     with frame_done; next slot 0 shows bcd_sel=8; release load -> no further ack.
//   4 value 0x0070 -> digits 3,2 segments_n=7'h7F with anodes driven; digit 1=7; digit 0=0;
//     value 0x0000 -> only digit 0 lit as "0". BLANK_LZ=0 -> all four show 0.
//   5 value 0x00A5, dp_in=4'b0010 -> digit 1 segments_n=7'b1111110, dp_n=0 only in digit 1 slot.
//   6 reset=0 one cycle during slot 2 with load held -> next cycle idx=0, all anodes off,
//     shadow=0, no ack; load taken and acked at the next frame boundary.

Source files
------------

// File: rtl/sevenseg_scan_ctrl_if.sv
// sevenseg_scan_ctrl_if: value/handshake and display-side signals of the 7-seg scan controller
interface sevenseg_scan_ctrl_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] bcd_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  load;
  logic                  load_ack;
  logic [3:0]            bcd_sel;
  logic [6:0]            seg_from_dec;
  logic [6:0]            segments_n;
  logic                  dp_n;
  logic [N_DIGITS-1:0]   anodes_n;
  logic                  frame_done;
  modport master (
    output bcd_in, dp_in, load, seg_from_dec,
    input  load_ack, bcd_sel, segments_n, dp_n, anodes_n, frame_done
  );
  modport slave (
    input  bcd_in, dp_in, load, seg_from_dec,
    output load_ack, bcd_sel, segments_n, dp_n, anodes_n, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: N-digit common-anode 7-seg scanner sharing one decoder, frame-aligned double buffer
module sevenseg_scan_ctrl #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4,
  parameter bit BLANK_LZ    = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  sevenseg_scan_ctrl_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [N_DIGITS-1:0] ONE = N_DIGITS'(1);
  typedef enum logic {S_GUARD, S_DRIVE} state_t;
  state_t                r_state, w_state_nxt;
  logic [PW-1:0]         r_presc, w_presc_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [4*N_DIGITS-1:0] r_bcd, w_bcd_nxt;
  logic [N_DIGITS-1:0]   r_dp, w_dp_nxt;
  logic [3:0]            r_bcd_sel, w_bcd_sel_nxt;
  logic                  r_invalid, w_invalid_nxt;
  logic                  r_blank, w_blank_nxt;
  logic [N_DIGITS-1:0]   r_anodes_n, w_anodes_nxt;
  logic                  r_dp_n, w_dp_n_nxt;
  logic                  r_load_ack, r_frame_done;
  logic                  w_term, w_last, w_boundary, w_take;
  // State register plus registered display drive; all outputs except segments_n come from here
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_GUARD;
      r_presc      <= '0;
      r_idx        <= '0;
      r_bcd        <= '0;
      r_dp         <= '0;
      r_bcd_sel    <= '0;
      r_invalid    <= 1'b0;
      r_blank      <= 1'b0;
      r_anodes_n   <= '1;
      r_dp_n       <= 1'b1;
      r_load_ack   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_presc      <= w_presc_nxt;
      r_idx        <= w_idx_nxt;
      r_bcd        <= w_bcd_nxt;
      r_dp         <= w_dp_nxt;
      r_bcd_sel    <= w_bcd_sel_nxt;
      r_invalid    <= w_invalid_nxt;
      r_blank      <= w_blank_nxt;
      r_anodes_n   <= w_anodes_nxt;
      r_dp_n       <= w_dp_n_nxt;
      r_load_ack   <= w_take;
      r_frame_done <= w_boundary;
    end
  end
  // Next slot position, boundary capture, and the flags the display needs for the upcoming cycle
  always_comb begin
    w_term        = r_presc == PW'(REFRESH_DIV - 1);
    w_last        = r_idx == IW'(N_DIGITS - 1);
    w_boundary    = w_term && w_last;
    w_take        = w_boundary && bus.load;
    w_presc_nxt   = w_term ? '0 : r_presc + 1'b1;
    w_idx_nxt     = w_term ? (w_last ? '0 : r_idx + 1'b1) : r_idx;
    w_state_nxt   = w_presc_nxt >= PW'(GUARD) ? S_DRIVE : S_GUARD;
    w_bcd_nxt     = w_take ? bus.bcd_in : r_bcd;
    w_dp_nxt      = w_take ? bus.dp_in : r_dp;
    w_bcd_sel_nxt = w_bcd_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_invalid_nxt = w_bcd_sel_nxt > 4'd9;
    w_blank_nxt   = BLANK_LZ && w_idx_nxt != '0 && (w_bcd_nxt >> {w_idx_nxt, 2'b00}) == '0;
    w_anodes_nxt  = w_state_nxt == S_DRIVE ? ~(ONE << w_idx_nxt) : '1;
    w_dp_n_nxt    = !(w_state_nxt == S_DRIVE && w_dp_nxt[w_idx_nxt]);
  end
  assign bus.segments_n = (r_state == S_GUARD || r_blank) ? 7'h7F :
                          (r_invalid ? 7'b1111110 : ~bus.seg_from_dec);
  assign bus.bcd_sel    = r_bcd_sel;
  assign bus.anodes_n   = r_anodes_n;
  assign bus.dp_n       = r_dp_n;
  assign bus.load_ack   = r_load_ack;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: scoreboard bench for the 7-seg scan controller (4 digits, 8-cycle slots)
module tb_sevenseg_scan_ctrl;
  localparam int N = 4;
  localparam int DIV = 8;
  localparam int G = 2;
  localparam int FRAME = N * DIV;
  typedef struct packed {logic [15:0] bcd; logic [3:0] dp;} ld_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_pass = 0;
  int n_total = 0;
  ld_t exp_q[$];
  ld_t shadow;
  bit seen;
  sevenseg_scan_ctrl_if #(.N_DIGITS(N)) u_if ();
  sevenseg_scan_ctrl_if #(.N_DIGITS(N)) u_if0 ();
  sevenseg_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(DIV), .GUARD(G), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .reset(reset), .bus(u_if.slave));
  sevenseg_scan_ctrl #(.N_DIGITS(N), .REFRESH_DIV(DIV), .GUARD(G), .BLANK_LZ(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(u_if0.slave));
  always #5 clk = ~clk;
  function automatic logic [6:0] dec(input logic [3:0] b);
    case (b)
      4'd0: dec = 7'h7E;
      4'd1: dec = 7'h30;
      4'd2: dec = 7'h6D;
      4'd3: dec = 7'h79;
      4'd4: dec = 7'h33;
      4'd5: dec = 7'h5B;
      4'd6: dec = 7'h5F;
      4'd7: dec = 7'h70;
      4'd8: dec = 7'h7F;
      4'd9: dec = 7'h7B;
      default: dec = 7'h55;
    endcase
  endfunction
  assign u_if.seg_from_dec  = dec(u_if.bcd_sel);
  assign u_if0.seg_from_dec = dec(u_if0.bcd_sel);
  assign u_if0.bcd_in = u_if.bcd_in;
  assign u_if0.dp_in  = u_if.dp_in;
  assign u_if0.load   = u_if.load;
  function automatic logic [3:0] exp_an(input int k);
    return (k % DIV < G) ? 4'hF : ~(4'b0001 << (k / DIV));
  endfunction
  function automatic logic [3:0] exp_sel(input ld_t s, input int k);
    return s.bcd[4*(k/DIV) +: 4];
  endfunction
  function automatic logic exp_dpn(input ld_t s, input int k);
    return (k % DIV < G) ? 1'b1 : ~s.dp[k/DIV];
  endfunction
  function automatic logic [6:0] exp_seg(input ld_t s, input int k, input bit blz);
    int i;
    logic [3:0] d;
    i = k / DIV;
    d = s.bcd[4*i +: 4];
    if (k % DIV < G) return 7'h7F;
    if (d > 4'd9) return 7'h7E;
    if (blz && i != 0 && (s.bcd >> (4*i)) == 16'h0) return 7'h7F;
    return ~dec(d);
  endfunction
  task automatic request(input logic [15:0] bcd, input logic [3:0] dp);
    ld_t v;
    v.bcd = bcd;
    v.dp = dp;
    u_if.bcd_in = bcd;
    u_if.dp_in = dp;
    u_if.load = 1'b1;
    exp_q.push_back(v);
  endtask
  task automatic wait_fd(output bit s);
    s = 1'b0;
    for (int c = 0; c < FRAME + 8 && !s; c++) begin
      @(negedge clk);
      s = u_if.frame_done;
    end
  endtask
  task automatic test_reset;
    reset = 1'b0;
    u_if.load = 1'b0;
    u_if.bcd_in = '0;
    u_if.dp_in = '0;
    repeat (2) @(negedge clk);
    n_total++; if (u_if.anodes_n !== 4'hF) $display("FAIL reset_anodes got %b exp 1111", u_if.anodes_n); else n_pass++;
    n_total++; if (u_if.segments_n !== 7'h7F) $display("FAIL reset_segments got %h exp 7f", u_if.segments_n); else n_pass++;
    n_total++; if (u_if.dp_n !== 1'b1) $display("FAIL reset_dp_n got %b exp 1", u_if.dp_n); else n_pass++;
    n_total++; if (u_if.load_ack !== 1'b0) $display("FAIL reset_load_ack got %b exp 0", u_if.load_ack); else n_pass++;
    n_total++; if (u_if.bcd_sel !== 4'h0) $display("FAIL reset_bcd_sel got %h exp 0", u_if.bcd_sel); else n_pass++;
    n_total++; if (u_if.frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", u_if.frame_done); else n_pass++;
    shadow = '0;
    exp_q.delete();
    reset = 1'b1;
  endtask
  task automatic test_scan;
    request(16'h1234, 4'h0);
    wait_fd(seen);
    n_total++; if (!seen) $display("FAIL scan_timeout got no frame_done exp one within %0d cycles", FRAME + 8); else n_pass++;
    if (u_if.load_ack && exp_q.size() > 0) shadow = exp_q.pop_front();
    u_if.load = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      n_total++; if (u_if.anodes_n !== exp_an(k)) $display("FAIL scan_anodes k=%0d got %b exp %b", k, u_if.anodes_n, exp_an(k)); else n_pass++;
      n_total++; if (u_if.bcd_sel !== exp_sel(shadow, k)) $display("FAIL scan_bcd_sel k=%0d got %h exp %h", k, u_if.bcd_sel, exp_sel(shadow, k)); else n_pass++;
      n_total++; if (u_if.segments_n !== exp_seg(shadow, k, 1'b1)) $display("FAIL scan_segments k=%0d got %h exp %h", k, u_if.segments_n, exp_seg(shadow, k, 1'b1)); else n_pass++;
      n_total++; if (u_if.dp_n !== exp_dpn(shadow, k)) $display("FAIL scan_dp_n k=%0d got %b exp %b", k, u_if.dp_n, exp_dpn(shadow, k)); else n_pass++;
      n_total++; if (u_if.frame_done !== (k == 0)) $display("FAIL scan_frame_done k=%0d got %b exp %b", k, u_if.frame_done, k == 0); else n_pass++;
      n_total++; if (u_if.load_ack !== (k == 0)) $display("FAIL scan_load_ack k=%0d got %b exp %b", k, u_if.load_ack, k == 0); else n_pass++;
    end
    @(negedge clk);
    n_total++; if (u_if.frame_done !== 1'b1) $display("FAIL scan_period got %b exp 1", u_if.frame_done); else n_pass++;
    n_total++; if (u_if.load_ack !== 1'b0) $display("FAIL scan_no_reack got %b exp 0", u_if.load_ack); else n_pass++;
  endtask
  task automatic test_hold;
    repeat (10) @(negedge clk);
    request(16'h5678, 4'h0);
    for (int k = 11; k < FRAME; k++) begin
      @(negedge clk);
      n_total++; if (u_if.bcd_sel !== exp_sel(shadow, k)) $display("FAIL hold_old_value k=%0d got %h exp %h", k, u_if.bcd_sel, exp_sel(shadow, k)); else n_pass++;
      n_total++; if (u_if.load_ack !== 1'b0) $display("FAIL hold_early_ack k=%0d got %b exp 0", k, u_if.load_ack); else n_pass++;
    end
    @(negedge clk);
    n_total++; if (u_if.frame_done !== 1'b1) $display("FAIL hold_frame_done got %b exp 1", u_if.frame_done); else n_pass++;
    n_total++; if (u_if.load_ack !== 1'b1) $display("FAIL hold_ack got %b exp 1", u_if.load_ack); else n_pass++;
    if (u_if.load_ack && exp_q.size() > 0) shadow = exp_q.pop_front();
    u_if.load = 1'b0;
    n_total++; if (u_if.bcd_sel !== 4'h8) $display("FAIL hold_first_digit got %h exp 8", u_if.bcd_sel); else n_pass++;
    for (int k = 1; k < FRAME; k++) begin
      @(negedge clk);
      n_total++; if (u_if.anodes_n !== exp_an(k)) $display("FAIL hold_anodes k=%0d got %b exp %b", k, u_if.anodes_n, exp_an(k)); else n_pass++;
      n_total++; if (u_if.bcd_sel !== exp_sel(shadow, k)) $display("FAIL hold_bcd_sel k=%0d got %h exp %h", k, u_if.bcd_sel, exp_sel(shadow, k)); else n_pass++;
      n_total++; if (u_if.load_ack !== 1'b0) $display("FAIL hold_extra_ack k=%0d got %b exp 0", k, u_if.load_ack); else n_pass++;
    end
    @(negedge clk);
    n_total++; if (u_if.load_ack !== 1'b0) $display("FAIL hold_released_ack got %b exp 0", u_if.load_ack); else n_pass++;
  endtask
  task automatic test_blank;
    logic [15:0] vals [2];
    vals[0] = 16'h0070;
    vals[1] = 16'h0000;
    for (int v = 0; v < 2; v++) begin
      request(vals[v], 4'h0);
      wait_fd(seen);
      n_total++; if (!seen) $display("FAIL blank_timeout got no frame_done exp one within %0d cycles", FRAME + 8); else n_pass++;
      n_total++; if (u_if.load_ack !== 1'b1) $display("FAIL blank_ack got %b exp 1", u_if.load_ack); else n_pass++;
      n_total++; if (u_if0.load_ack !== 1'b1) $display("FAIL blank_ack_nolz got %b exp 1", u_if0.load_ack); else n_pass++;
      if (u_if.load_ack && exp_q.size() > 0) shadow = exp_q.pop_front();
      u_if.load = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) @(negedge clk);
        n_total++; if (u_if.anodes_n !== exp_an(k)) $display("FAIL blank_anodes v=%h k=%0d got %b exp %b", vals[v], k, u_if.anodes_n, exp_an(k)); else n_pass++;
        n_total++; if (u_if.segments_n !== exp_seg(shadow, k, 1'b1)) $display("FAIL blank_segments v=%h k=%0d got %h exp %h", vals[v], k, u_if.segments_n, exp_seg(shadow, k, 1'b1)); else n_pass++;
        n_total++; if (u_if0.anodes_n !== exp_an(k)) $display("FAIL nolz_anodes v=%h k=%0d got %b exp %b", vals[v], k, u_if0.anodes_n, exp_an(k)); else n_pass++;
        n_total++; if (u_if0.segments_n !== exp_seg(shadow, k, 1'b0)) $display("FAIL nolz_segments v=%h k=%0d got %h exp %h", vals[v], k, u_if0.segments_n, exp_seg(shadow, k, 1'b0)); else n_pass++;
      end
    end
  endtask
  task automatic test_invalid;
    request(16'h00A5, 4'b0010);
    wait_fd(seen);
    n_total++; if (!seen) $display("FAIL invalid_timeout got no frame_done exp one within %0d cycles", FRAME + 8); else n_pass++;
    n_total++; if (u_if.load_ack !== 1'b1) $display("FAIL invalid_ack got %b exp 1", u_if.load_ack); else n_pass++;
    if (u_if.load_ack && exp_q.size() > 0) shadow = exp_q.pop_front();
    u_if.load = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      n_total++; if (u_if.segments_n !== exp_seg(shadow, k, 1'b1)) $display("FAIL invalid_segments k=%0d got %h exp %h", k, u_if.segments_n, exp_seg(shadow, k, 1'b1)); else n_pass++;
      n_total++; if (u_if.dp_n !== exp_dpn(shadow, k)) $display("FAIL invalid_dp_n k=%0d got %b exp %b", k, u_if.dp_n, exp_dpn(shadow, k)); else n_pass++;
      n_total++; if (u_if.bcd_sel !== exp_sel(shadow, k)) $display("FAIL invalid_bcd_sel k=%0d got %h exp %h", k, u_if.bcd_sel, exp_sel(shadow, k)); else n_pass++;
    end
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    repeat (2 * DIV + 2) @(negedge clk);
    reset = 1'b0;
    request(16'h4321, 4'b0001);
    @(negedge clk);
    reset = 1'b1;
    shadow = '0;
    n_total++; if (u_if.load_ack !== 1'b0) $display("FAIL rstmid_ack got %b exp 0", u_if.load_ack); else n_pass++;
    n_total++; if (u_if.frame_done !== 1'b0) $display("FAIL rstmid_frame_done got %b exp 0", u_if.frame_done); else n_pass++;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      n_total++; if (u_if.anodes_n !== exp_an(k)) $display("FAIL rstmid_anodes k=%0d got %b exp %b", k, u_if.anodes_n, exp_an(k)); else n_pass++;
      n_total++; if (u_if.bcd_sel !== exp_sel(shadow, k)) $display("FAIL rstmid_bcd_sel k=%0d got %h exp %h", k, u_if.bcd_sel, exp_sel(shadow, k)); else n_pass++;
      n_total++; if (u_if.segments_n !== exp_seg(shadow, k, 1'b1)) $display("FAIL rstmid_segments k=%0d got %h exp %h", k, u_if.segments_n, exp_seg(shadow, k, 1'b1)); else n_pass++;
      n_total++; if (u_if.dp_n !== exp_dpn(shadow, k)) $display("FAIL rstmid_dp_n k=%0d got %b exp %b", k, u_if.dp_n, exp_dpn(shadow, k)); else n_pass++;
      n_total++; if (u_if.load_ack !== 1'b0) $display("FAIL rstmid_early_ack k=%0d got %b exp 0", k, u_if.load_ack); else n_pass++;
    end
    @(negedge clk);
    n_total++; if (u_if.frame_done !== 1'b1) $display("FAIL rstmid_boundary got %b exp 1", u_if.frame_done); else n_pass++;
    n_total++; if (u_if.load_ack !== 1'b1) $display("FAIL rstmid_ack_after got %b exp 1", u_if.load_ack); else n_pass++;
    if (u_if.load_ack && exp_q.size() > 0) shadow = exp_q.pop_front();
    u_if.load = 1'b0;
    n_total++; if (u_if.bcd_sel !== exp_sel(shadow, 0)) $display("FAIL rstmid_new_value got %h exp %h", u_if.bcd_sel, exp_sel(shadow, 0)); else n_pass++;
    n_total++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); else n_pass++;
  endtask
  initial begin
    test_reset();
    test_scan();
    test_hold();
    test_blank();
    test_invalid();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
